mfp_ahb_uart_tx: RTL and testbench

MFP_AHB_UART_TX -- requirements
Module: mfp_ahb_uart_tx

---
 rtl/mfp_ahb_uart_tx_pkg.sv | 43 ++++
 rtl/mfp_uart_tx_fifo.sv | 52 +++++
 rtl/mfp_ahb_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_mfp_ahb_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB-Lite UART transmitter: register offsets,
// STATUS bit positions, serializer state codes and the data-phase record.
package mfp_ahb_uart_tx_pkg;

  // Word offsets decoded from HADDR[3:2]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // Serializer states
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [1:0] offset;
  } dphase_t;

  // Assemble the STATUS word from its fields
  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [3:0] cnt);
    logic [31:0] w;
    w                     = '0;
    w[STAT_FULL]          = full;
    w[STAT_EMPTY]         = empty;
    w[STAT_BUSY]          = busy;
    w[STAT_OVF]           = ovf;
    w[STAT_CNT_LSB +: 4]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer. dout shows the head entry
// combinationally so a pop can load it on the same edge. A push while full
// is only taken when a pop frees a slot on the same edge.
module mfp_uart_tx_fifo
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave with an 8N1 UART transmitter behind a small byte FIFO.
// Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY; the
// slave never stalls (HREADYOUT=1), so the data phase always completes on the
// next edge. Inside, push/pop are single-cycle strobes qualified by full/empty.
module mfp_ahb_uart_tx
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        UART_TX,
  output logic [1:0]  dbg_state
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  dphase_t             dp_q;
  logic                addr_ok;
  logic                push_req;
  logic                stat_wr;
  logic                overflow;
  logic                fifo_pop;
  logic [7:0]          fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_AW:0]    fifo_count;
  logic [31:0]         count_wide;
  logic [3:0]          cnt_sat;
  logic                busy;
  logic [1:0]          state;
  logic [BAUD_W-1:0]   baud;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                tx_q;
  logic                unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign UART_TX   = tx_q;
  assign dbg_state = state;

  assign addr_ok  = HSEL & HTRANS[1] & HREADY;
  assign push_req = dp_q.valid & dp_q.write & (dp_q.offset == OFF_TXDATA);
  assign stat_wr  = dp_q.valid & dp_q.write & (dp_q.offset == OFF_STATUS);

  // Pop when idle, or at the last cycle of a stop bit to chain frames
  assign fifo_pop = ~fifo_empty &
                    ((state == TX_IDLE) | ((state == TX_STOP) & (baud == BAUD_LAST)));

  assign busy       = (state != TX_IDLE) | ~fifo_empty;
  assign count_wide = 32'(fifo_count);
  assign cnt_sat    = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

  mfp_uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (HWDATA[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register the accepted address phase for the following data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_q <= '0;
    end else begin
      dp_q.valid  <= addr_ok;
      dp_q.write  <= addr_ok & HWRITE;
      dp_q.offset <= addr_ok ? HADDR[3:2] : 2'd0;
    end
  end

  // Sticky overflow: a dropped push sets it, a STATUS write of bit 3 clears it
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow <= 1'b0;
    end else if (push_req & fifo_full & ~fifo_pop) begin
      overflow <= 1'b1;
    end else if (stat_wr & HWDATA[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Read data from the registered offset; zero unless a STATUS read
  always_comb begin
    HRDATA = '0;
    if (dp_q.valid & ~dp_q.write & (dp_q.offset == OFF_STATUS)) begin
      HRDATA = status_word(fifo_full, fifo_empty, busy, overflow, cnt_sat);
    end
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          tx_q <= 1'b1;
          baud <= '0;
          if (fifo_pop) begin
            shreg <= fifo_dout;
            state <= TX_START;
            tx_q  <= 1'b0;
          end
        end
        TX_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= TX_DATA;
            tx_q    <= shreg[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx_q  <= 1'b1;
            end else begin
              tx_q  <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (fifo_pop) begin
              shreg <= fifo_dout;
              state <= TX_START;
              tx_q  <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Bench for mfp_ahb_uart_tx with CLKS_PER_BIT=4, FIFO_AW=3. A frame-level
// model (byte queue plus frame timeline) predicts UART_TX, HRDATA and idle
// state every cycle; directed tests add literal expectations.
module tb_mfp_ahb_uart_tx;
  import mfp_ahb_uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = '0;
  logic        HWRITE  = 1'b0;
  logic        HREADY  = 1'b1;
  logic [31:0] HWDATA  = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        UART_TX;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_buf [16];

  always #5 HCLK = ~HCLK;

  mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .UART_TX   (UART_TX),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] m_q [$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_ovf;
  bit         m_dpv;
  bit         m_dpw;
  logic [1:0] m_dpo;

  function automatic logic exp_line();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int          n;
    logic [31:0] w;
    n      = m_q.size();
    w      = '0;
    w[0]   = (n == DEPTH);
    w[1]   = (n == 0);
    w[2]   = m_active || (n != 0);
    w[3]   = m_ovf;
    w[7:4] = (n > 15) ? 4'hF : 4'(n);
    return w;
  endfunction

  function automatic logic [31:0] exp_hrdata();
    if (m_dpv && !m_dpw && m_dpo == 2'd1) return exp_status();
    return 32'h0;
  endfunction

  // Frame timeline: each frame is 10 bit slots of CPB cycles; frames chain
  // back to back while bytes wait, otherwise the line idles.
  always @(posedge HCLK or negedge HRESETn) begin
    bit popped;
    bit push_req;
    bit clr;
    bit was_full;
    if (!HRESETn) begin
      m_q.delete();
      m_active = 0;
      m_t      = 0;
      m_byte   = '0;
      m_ovf    = 0;
      m_dpv    = 0;
      m_dpw    = 0;
      m_dpo    = '0;
    end else begin
      popped   = 0;
      push_req = m_dpv && m_dpw && (m_dpo == 2'd0);
      clr      = m_dpv && m_dpw && (m_dpo == 2'd1) && HWDATA[3];
      was_full = (m_q.size() == DEPTH);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * CPB) begin
          if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_t    = 0;
            popped = 1;
          end else begin
            m_active = 0;
          end
        end
      end else if (m_q.size() > 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1;
        m_t      = 0;
        popped   = 1;
      end
      if (clr) m_ovf = 0;
      if (push_req) begin
        if (was_full && !popped) m_ovf = 1;
        else m_q.push_back(HWDATA[7:0]);
      end
      m_dpv = HSEL && HTRANS[1] && HREADY;
      m_dpw = HWRITE;
      m_dpo = HADDR[3:2];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge HCLK) begin
    check("uart_tx", 32'(UART_TX), 32'(exp_line()));
    check("hrdata", HRDATA, exp_hrdata());
    check("hreadyout", 32'(HREADYOUT), 32'h1);
    check("hresp", 32'(HRESP), 32'h0);
    check("fsm_idle", 32'(dbg_state == TX_IDLE), 32'(!m_active));
  end

  // ---------------- driver tasks ----------------
  task automatic write_buf(input int n, input logic [31:0] addr);
    @(posedge HCLK); #1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
      end
      HWDATA = (i > 0) ? {24'h0, wr_buf[i-1]} : 32'h0;
      @(posedge HCLK); #1;
    end
    HWDATA = '0;
  endtask

  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic rdy, input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HREADY = rdy; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HADDR = '0; HWDATA = data;
    @(posedge HCLK); #1;
    HWDATA = '0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
    @(negedge HCLK);
    check(name, HRDATA, exp);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge HCLK);
      if (UART_TX !== 1'b1) lows++;
    end
  endtask

  // Wait (bounded) for a start bit, then compare nbits slots against pat,
  // where pat[k] is the level of slot k in transmission order.
  task automatic capture(input string name, input int nbits, input logic [19:0] pat,
                         output int waited);
    logic [19:0] p;
    p      = pat;
    waited = 0;
    do begin
      @(negedge HCLK);
      waited++;
    end while (UART_TX !== 1'b0 && waited < 20);
    check({name, "_start_seen"}, 32'(UART_TX), 32'h0);
    for (int i = 0; i < nbits * CPB; i++) begin
      if (i > 0) @(negedge HCLK);
      check($sformatf("%s_slot%0d", name, i / CPB), 32'(UART_TX), 32'(p[i / CPB]));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    int lows;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("reset_tx", 32'(UART_TX), 32'h1);
    check("reset_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;

    // Register map reads on an idle block
    read_check(32'h4, 32'h2, "status_idle");
    read_check(32'h0, 32'h0, "txdata_reads_zero");
    read_check(32'hC, 32'h0, "reserved_reads_zero");

    // Transfers that must not push
    xfer(1'b0, 2'b10, 1'b1, 1'b1, 32'h0, 32'hA5);
    xfer(1'b1, 2'b00, 1'b1, 1'b1, 32'h0, 32'hA5);
    xfer(1'b1, 2'b10, 1'b1, 1'b0, 32'h0, 32'hA5);
    xfer(1'b1, 2'b10, 1'b1, 1'b1, 32'hC, 32'hAB);
    xfer(1'b1, 2'b10, 1'b1, 1'b1, 32'h8, 32'hCD);
    count_lows(12, lows);
    check("no_push_line_high", 32'(lows), 32'h0);
    read_check(32'h4, 32'h2, "status_after_ignored");

    // Single frame 0x55
    wr_buf[0] = 8'h55;
    write_buf(1, 32'h0);
    capture("f55", 10, {10'b0, 10'b1010101010}, waited);
    check("start_latency_ok", 32'(waited <= 3), 32'h1);
    read_check(32'h4, 32'h2, "status_after_55");

    // Two frames back to back, no idle gap
    wr_buf[0] = 8'hA3;
    wr_buf[1] = 8'h0F;
    write_buf(2, 32'h0);
    capture("fa3_0f", 20, {10'b1000011110, 10'b1101000110}, waited);
    read_check(32'h4, 32'h2, "status_after_pair");

    // Overflow: 10 writes, 1 in the serializer, 8 queued, 1 dropped
    for (int i = 0; i < 10; i++) wr_buf[i] = 8'h10 + 8'(i);
    write_buf(10, 32'h0);
    read_check(32'h4, 32'h8D, "status_overflow");
    wr_buf[0] = 8'h08;
    write_buf(1, 32'h4);
    read_check(32'h4, 32'h85, "status_ovf_cleared");
    repeat (420) @(posedge HCLK);
    read_check(32'h4, 32'h2, "status_drained");

    // Reset during data bit 3 with three bytes queued
    wr_buf[0] = 8'h00;
    wr_buf[1] = 8'h11;
    wr_buf[2] = 8'h22;
    wr_buf[3] = 8'h33;
    write_buf(4, 32'h0);
    waited = 0;
    do begin
      @(negedge HCLK);
      waited++;
    end while (UART_TX !== 1'b0 && waited < 20);
    check("rst_frame_started", 32'(UART_TX), 32'h0);
    repeat (4 * CPB) @(negedge HCLK);
    check("bit3_low_before_reset", 32'(UART_TX), 32'h0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_reset_tx", 32'(UART_TX), 32'h1);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    read_check(32'h4, 32'h2, "status_after_reset");
    count_lows(60, lows);
    check("no_frame_after_reset", 32'(lows), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
